// File: rtl/gpio_cmd_rx_pkg.sv
// Shared constants and types for the GPIO configuration frame receiver.
// The command ID and param codes are also used by the interrupt-frame generator.
package gpio_cmd_rx_pkg;

    localparam logic [7:0] GPIO_CMD_ID    = 8'h47;
    localparam logic [7:0] PARAM_LEVEL    = 8'h6c;
    localparam logic [7:0] PARAM_DIR      = 8'h64;
    localparam logic [7:0] PARAM_INT      = 8'h69;
    localparam logic [7:0] GPIO_FRAME_LEN = 8'd4;

    typedef enum logic [2:0] {
        IDLE,
        HDR_CTR,
        HDR_LEN,
        PARAM,
        DATA,
        CHECK,
        DISCARD
    } rx_state_e;

    function automatic logic is_valid_param(input logic [7:0] p);
        return (p == PARAM_LEVEL) || (p == PARAM_DIR) || (p == PARAM_INT);
    endfunction

endpackage

// File: rtl/gpio_cmd_rx.sv
// Receives GPIO configuration frames from the host byte stream and applies the
// 24-bit payload to the level, direction or interrupt-enable register at frame end.
module gpio_cmd_rx
    import gpio_cmd_rx_pkg::*;
#(
    parameter int         GPIO_WIDTH = 24,
    parameter logic [7:0] CMD_ID     = GPIO_CMD_ID
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_data_valid,
    input  logic                  in_frame_valid,
    output logic [GPIO_WIDTH-1:0] gpio_level,
    output logic [GPIO_WIDTH-1:0] gpio_direction,
    output logic [GPIO_WIDTH-1:0] gpio_int_enable,
    output logic                  ack_valid,
    output logic                  ack_err
);

    rx_state_e             state_q, state_d;
    logic                  frame_prev_q, frame_prev_d;
    logic                  armed_q, armed_d;
    logic                  extra_q, extra_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            param_q, param_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [GPIO_WIDTH-1:0] shadow_q, shadow_d;
    logic [GPIO_WIDTH-1:0] level_q, level_d;
    logic [GPIO_WIDTH-1:0] dir_q, dir_d;
    logic [GPIO_WIDTH-1:0] inten_q, inten_d;
    logic                  ack_valid_q, ack_valid_d;
    logic                  ack_err_q, ack_err_d;

    logic byte_acc;
    logic frame_start;
    logic frame_end;
    logic frame_err;

    assign byte_acc    = in_data_valid & in_frame_valid;
    assign frame_start = in_frame_valid & ~frame_prev_q;
    assign frame_end   = ~in_frame_valid & frame_prev_q;
    assign frame_err   = (len_q != GPIO_FRAME_LEN) | ~is_valid_param(param_q) | extra_q;

    // armed_q remembers a seen frame start while IDLE waits for the ID byte;
    // a high in_frame_valid without a seen start is a frame we joined late.
    always_comb begin
        state_d      = state_q;
        frame_prev_d = in_frame_valid;
        armed_d      = 1'b0;
        extra_d      = extra_q;
        len_d        = len_q;
        param_d      = param_q;
        byte_cnt_d   = byte_cnt_q;
        shadow_d     = shadow_q;
        level_d      = level_q;
        dir_d        = dir_q;
        inten_d      = inten_q;
        ack_valid_d  = 1'b0;
        ack_err_d    = 1'b0;

        if (frame_end) begin
            state_d    = IDLE;
            byte_cnt_d = 2'd0;
            case (state_q)
                IDLE, DISCARD: ;
                CHECK: begin
                    ack_valid_d = 1'b1;
                    if (frame_err) begin
                        ack_err_d = 1'b1;
                    end else begin
                        case (param_q)
                            PARAM_LEVEL: level_d = shadow_q;
                            PARAM_DIR:   dir_d   = shadow_q;
                            PARAM_INT:   inten_d = shadow_q;
                            default: ;
                        endcase
                    end
                end
                default: begin
                    ack_valid_d = 1'b1;
                    ack_err_d   = 1'b1;
                end
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_frame_valid) begin
                        if (frame_start || armed_q) begin
                            if (in_data_valid) begin
                                state_d    = (in_data == CMD_ID) ? HDR_CTR : DISCARD;
                                extra_d    = 1'b0;
                                byte_cnt_d = 2'd0;
                            end else begin
                                armed_d = 1'b1;
                            end
                        end else begin
                            state_d = DISCARD;
                        end
                    end
                end
                HDR_CTR: begin
                    if (byte_acc) state_d = HDR_LEN;
                end
                HDR_LEN: begin
                    if (byte_acc) begin
                        len_d   = in_data;
                        state_d = PARAM;
                    end
                end
                PARAM: begin
                    if (byte_acc) begin
                        param_d = in_data;
                        state_d = DATA;
                    end
                end
                DATA: begin
                    if (byte_acc) begin
                        shadow_d = {shadow_q[GPIO_WIDTH-9:0], in_data};
                        if (byte_cnt_q == 2'd2) begin
                            byte_cnt_d = 2'd0;
                            state_d    = CHECK;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 2'd1;
                        end
                    end
                end
                CHECK: begin
                    if (byte_acc) extra_d = 1'b1;
                end
                DISCARD: ;
                default: state_d = IDLE;
            endcase
        end
    end

    // The edge detector resets high so a frame already in flight at reset
    // release is not mistaken for a fresh frame start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            frame_prev_q <= 1'b1;
            armed_q      <= 1'b0;
            extra_q      <= 1'b0;
            len_q        <= '0;
            param_q      <= '0;
            byte_cnt_q   <= '0;
            shadow_q     <= '0;
            level_q      <= '0;
            dir_q        <= '0;
            inten_q      <= '0;
            ack_valid_q  <= 1'b0;
            ack_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_prev_q <= frame_prev_d;
            armed_q      <= armed_d;
            extra_q      <= extra_d;
            len_q        <= len_d;
            param_q      <= param_d;
            byte_cnt_q   <= byte_cnt_d;
            shadow_q     <= shadow_d;
            level_q      <= level_d;
            dir_q        <= dir_d;
            inten_q      <= inten_d;
            ack_valid_q  <= ack_valid_d;
            ack_err_q    <= ack_err_d;
        end
    end

    assign gpio_level      = level_q;
    assign gpio_direction  = dir_q;
    assign gpio_int_enable = inten_q;
    assign ack_valid       = ack_valid_q;
    assign ack_err         = ack_err_q;

endmodule

// File: tb/tb_gpio_cmd_rx.sv
// Self-checking bench for gpio_cmd_rx: directed frames plus randomized frames
// compared against a frame-level reference model.
module tb_gpio_cmd_rx;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_data_valid;
    logic        in_frame_valid;
    logic [23:0] gpio_level;
    logic [23:0] gpio_direction;
    logic [23:0] gpio_int_enable;
    logic        ack_valid;
    logic        ack_err;

    int checks = 0;
    int fails = 0;
    int ack_seen = 0;
    int ack_expected = 0;

    logic [23:0] m_level = '0;
    logic [23:0] m_dir = '0;
    logic [23:0] m_int = '0;

    gpio_cmd_rx dut (
        .clk            (clk),
        .reset          (reset),
        .in_data        (in_data),
        .in_data_valid  (in_data_valid),
        .in_frame_valid (in_frame_valid),
        .gpio_level     (gpio_level),
        .gpio_direction (gpio_direction),
        .gpio_int_enable(gpio_int_enable),
        .ack_valid      (ack_valid),
        .ack_err        (ack_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (ack_valid === 1'b1) ack_seen++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame-level model: 0 = not a GPIO frame, 1 = applied, 2 = rejected.
    function automatic int model_frame(input bq_t b);
        if (b.size() == 0 || b[0] != 8'h47) return 0;
        if (b.size() != 7 || b[2] != 8'd4) return 2;
        case (b[3])
            8'h6c: m_level = {b[4], b[5], b[6]};
            8'h64: m_dir   = {b[4], b[5], b[6]};
            8'h69: m_int   = {b[4], b[5], b[6]};
            default: return 2;
        endcase
        return 1;
    endfunction

    // Drives one frame, ends it with a single low cycle of in_frame_valid and
    // returns in the cycle after frame end. snap holds the outputs seen during
    // the frame-end cycle, before the update edge.
    task automatic send_frame(input bq_t b, input bit gaps, output logic [71:0] snap);
        in_frame_valid = 1'b1;
        for (int i = 0; i < b.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_data_valid = 1'b0;
                in_data       = 8'($urandom);
                tick();
            end
            in_data_valid = 1'b1;
            in_data       = b[i];
            tick();
        end
        in_data_valid  = 1'b0;
        in_frame_valid = 1'b0;
        #1;
        snap = {gpio_level, gpio_direction, gpio_int_enable};
        tick();
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++; if (gpio_level !== 24'h0) begin fails++; $display("FAIL reset_level got %h expected %h", gpio_level, 24'h0); end
        checks++; if (gpio_direction !== 24'h0) begin fails++; $display("FAIL reset_dir got %h expected %h", gpio_direction, 24'h0); end
        checks++; if (gpio_int_enable !== 24'h0) begin fails++; $display("FAIL reset_int got %h expected %h", gpio_int_enable, 24'h0); end
        checks++; if (ack_valid !== 1'b0 || ack_err !== 1'b0) begin fails++; $display("FAIL reset_ack got %b/%b expected 0/0", ack_valid, ack_err); end
        reset = 1'b0;
        repeat (2) tick();
        checks++; if (ack_valid !== 1'b0) begin fails++; $display("FAIL post_reset_ack got %b expected 0", ack_valid); end
    endtask

    task automatic test_level_frame();
        bq_t f;
        logic [71:0] snap;
        f = '{8'h47, 8'h05, 8'h04, 8'h6c, 8'hA5, 8'h5A, 8'h0F};
        send_frame(f, 1'b0, snap);
        checks++; if (snap[71:48] !== 24'h0) begin fails++; $display("FAIL level_latency early got %h expected %h", snap[71:48], 24'h0); end
        checks++; if (gpio_level !== 24'hA55A0F) begin fails++; $display("FAIL level_value got %h expected %h", gpio_level, 24'hA55A0F); end
        checks++; if (ack_valid !== 1'b1 || ack_err !== 1'b0) begin fails++; $display("FAIL level_ack got %b/%b expected 1/0", ack_valid, ack_err); end
        checks++; if (gpio_direction !== 24'h0 || gpio_int_enable !== 24'h0) begin fails++; $display("FAIL level_others got %h/%h expected 0/0", gpio_direction, gpio_int_enable); end
        m_level = 24'hA55A0F;
        ack_expected++;
        tick();
        checks++; if (ack_valid !== 1'b0) begin fails++; $display("FAIL level_ack_pulse got %b expected 0", ack_valid); end
    endtask

    task automatic test_back_to_back();
        bq_t f;
        logic [71:0] snap;
        f = '{8'h47, 8'h00, 8'h04, 8'h64, 8'hFF, 8'h00, 8'h01};
        send_frame(f, 1'b0, snap);
        checks++; if (gpio_direction !== 24'hFF0001) begin fails++; $display("FAIL b2b_dir got %h expected %h", gpio_direction, 24'hFF0001); end
        checks++; if (ack_valid !== 1'b1 || ack_err !== 1'b0) begin fails++; $display("FAIL b2b_ack1 got %b/%b expected 1/0", ack_valid, ack_err); end
        m_dir = 24'hFF0001;
        ack_expected++;
        f = '{8'h47, 8'h01, 8'h04, 8'h69, 8'h00, 8'h00, 8'h03};
        send_frame(f, 1'b0, snap);
        checks++; if (gpio_int_enable !== 24'h000003) begin fails++; $display("FAIL b2b_int got %h expected %h", gpio_int_enable, 24'h000003); end
        checks++; if (ack_valid !== 1'b1 || ack_err !== 1'b0) begin fails++; $display("FAIL b2b_ack2 got %b/%b expected 1/0", ack_valid, ack_err); end
        checks++; if (gpio_direction !== 24'hFF0001 || gpio_level !== m_level) begin fails++; $display("FAIL b2b_hold got %h/%h expected %h/%h", gpio_direction, gpio_level, 24'hFF0001, m_level); end
        m_int = 24'h000003;
        ack_expected++;
        tick();
    endtask

    task automatic test_wrong_id();
        bq_t f;
        logic [71:0] snap;
        f = '{8'h52, 8'h00, 8'h04, 8'h6c, 8'h11, 8'h22, 8'h33};
        send_frame(f, 1'b0, snap);
        checks++; if (ack_valid !== 1'b0) begin fails++; $display("FAIL wrong_id_ack got %b expected 0", ack_valid); end
        checks++; if (gpio_level !== m_level) begin fails++; $display("FAIL wrong_id_level got %h expected %h", gpio_level, m_level); end
        tick();
    endtask

    task automatic test_errors();
        bq_t frames[5];
        logic [71:0] snap;
        frames[0] = '{8'h47, 8'h00, 8'h04, 8'h6c, 8'h11, 8'h22};
        frames[1] = '{8'h47, 8'h00, 8'h04, 8'h6c, 8'h11, 8'h22, 8'h33, 8'h44};
        frames[2] = '{8'h47, 8'h00, 8'h03, 8'h6c, 8'h11, 8'h22, 8'h33};
        frames[3] = '{8'h47, 8'h00, 8'h04, 8'h7a, 8'h11, 8'h22, 8'h33};
        frames[4] = '{8'h47, 8'h00, 8'h04};
        for (int i = 0; i < 5; i++) begin
            send_frame(frames[i], 1'b0, snap);
            checks++; if (ack_valid !== 1'b1 || ack_err !== 1'b1) begin fails++; $display("FAIL error_ack[%0d] got %b/%b expected 1/1", i, ack_valid, ack_err); end
            checks++; if (gpio_level !== m_level) begin fails++; $display("FAIL error_level[%0d] got %h expected %h", i, gpio_level, m_level); end
            ack_expected++;
            tick();
        end
    endtask

    task automatic test_reset_midframe();
        bq_t head;
        bq_t f;
        logic [71:0] snap;
        head = '{8'h47, 8'h00, 8'h04, 8'h6c, 8'hA5};
        in_frame_valid = 1'b1;
        for (int i = 0; i < head.size(); i++) begin
            in_data_valid = 1'b1;
            in_data       = head[i];
            tick();
        end
        in_data_valid = 1'b0;
        reset = 1'b1;
        #2;
        checks++; if ({gpio_level, gpio_direction, gpio_int_enable} !== 72'h0) begin fails++; $display("FAIL async_reset got %h expected 0", {gpio_level, gpio_direction, gpio_int_enable}); end
        reset = 1'b0;
        m_level = '0;
        m_dir   = '0;
        m_int   = '0;
        tick();
        in_data_valid = 1'b1; in_data = 8'h5A; tick();
        in_data_valid = 1'b1; in_data = 8'h0F; tick();
        in_data_valid  = 1'b0;
        in_frame_valid = 1'b0;
        tick();
        checks++; if (ack_valid !== 1'b0) begin fails++; $display("FAIL reset_drop_ack got %b expected 0", ack_valid); end
        checks++; if (gpio_level !== 24'h0) begin fails++; $display("FAIL reset_drop_level got %h expected %h", gpio_level, 24'h0); end
        f = '{8'h47, 8'h00, 8'h04, 8'h6c, 8'h00, 8'h00, 8'h01};
        send_frame(f, 1'b0, snap);
        checks++; if (gpio_level !== 24'h000001) begin fails++; $display("FAIL after_reset_level got %h expected %h", gpio_level, 24'h000001); end
        checks++; if (ack_valid !== 1'b1 || ack_err !== 1'b0) begin fails++; $display("FAIL after_reset_ack got %b/%b expected 1/0", ack_valid, ack_err); end
        m_level = 24'h000001;
        ack_expected++;
        tick();
    endtask

    task automatic test_idle_valid();
        bq_t f;
        logic [71:0] snap;
        int kind;
        in_frame_valid = 1'b0;
        repeat (3) begin
            in_data_valid = 1'b1;
            in_data       = 8'h47;
            tick();
        end
        in_data_valid = 1'b0;
        tick();
        checks++; if (ack_valid !== 1'b0 || ack_seen !== ack_expected) begin fails++; $display("FAIL idle_valid_ack got %b/%0d expected 0/%0d", ack_valid, ack_seen, ack_expected); end
        f = '{8'h47, 8'h00, 8'h04, 8'h64, 8'h12, 8'h34, 8'h56};
        kind = model_frame(f);
        send_frame(f, 1'b0, snap);
        checks++; if (gpio_direction !== m_dir || ack_valid !== (kind != 0)) begin fails++; $display("FAIL idle_then_frame got %h/%b expected %h/%b", gpio_direction, ack_valid, m_dir, kind != 0); end
        if (kind != 0) ack_expected++;
        tick();
    endtask

    task automatic test_random();
        bq_t f;
        logic [71:0] snap;
        logic [71:0] old;
        int kind;
        int len;
        for (int n = 0; n < 80; n++) begin
            f = {};
            len = ($urandom_range(0, 9) < 7) ? 7 : int'($urandom_range(1, 9));
            for (int i = 0; i < len; i++) f.push_back(8'($urandom));
            if ($urandom_range(0, 9) != 0) f[0] = 8'h47;
            if (len > 2 && $urandom_range(0, 9) < 8) f[2] = 8'h04;
            if (len > 3) begin
                case ($urandom_range(0, 3))
                    0: f[3] = 8'h6c;
                    1: f[3] = 8'h64;
                    2: f[3] = 8'h69;
                    default: ;
                endcase
            end
            old  = {m_level, m_dir, m_int};
            kind = model_frame(f);
            send_frame(f, 1'b1, snap);
            checks++; if (snap !== old) begin fails++; $display("FAIL rand[%0d] early_update got %h expected %h", n, snap, old); end
            checks++; if (ack_valid !== (kind != 0)) begin fails++; $display("FAIL rand[%0d] ack_valid got %b expected %b", n, ack_valid, kind != 0); end
            if (kind != 0) begin
                checks++; if (ack_err !== (kind == 2)) begin fails++; $display("FAIL rand[%0d] ack_err got %b expected %b", n, ack_err, kind == 2); end
                ack_expected++;
            end
            checks++; if ({gpio_level, gpio_direction, gpio_int_enable} !== {m_level, m_dir, m_int}) begin fails++; $display("FAIL rand[%0d] regs got %h expected %h", n, {gpio_level, gpio_direction, gpio_int_enable}, {m_level, m_dir, m_int}); end
            repeat ($urandom_range(0, 2)) begin
                in_data_valid = 1'($urandom);
                in_data       = 8'($urandom);
                tick();
            end
            in_data_valid = 1'b0;
        end
        tick();
        checks++; if (ack_seen !== ack_expected) begin fails++; $display("FAIL ack_count got %0d expected %0d", ack_seen, ack_expected); end
    endtask

    initial begin
        reset          = 1'b1;
        in_data        = '0;
        in_data_valid  = 1'b0;
        in_frame_valid = 1'b0;
        #1;
        test_reset();
        test_level_frame();
        test_back_to_back();
        test_wrong_id();
        test_errors();
        test_reset_midframe();
        test_idle_valid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
